// File: rtl/display_pkg.sv
// Shared types and constants for the display sequencer and its neighbours.
package display_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHOW  = 2'd1,
    BLANK = 2'd2
  } seq_state_t;

  localparam int NIBBLE_W = 4;

  localparam logic [7:0] DWELL_DEFAULT = 8'd49;

endpackage

// File: rtl/display_sequencer_if.sv
// Control/write bus and decoder-facing outputs of the display sequencer.
interface display_sequencer_if #(
    parameter int DEPTH   = 4,
    parameter int DWELL_W = 8
);
    import display_pkg::*;

    localparam int IW = $clog2(DEPTH);

    logic                wr_valid;
    logic [NIBBLE_W-1:0] wr_data;
    logic                wr_ready;
    logic                clear;
    logic                start;
    logic                stop;
    logic [DWELL_W-1:0]  dwell;
    logic [NIBBLE_W-1:0] code_out;
    logic                code_valid;
    logic [IW-1:0]       idx;
    logic                busy;
    logic                wrap;

    modport master (
        output wr_valid, wr_data, clear, start, stop, dwell,
        input  wr_ready, code_out, code_valid, idx, busy, wrap
    );

    modport slave (
        input  wr_valid, wr_data, clear, start, stop, dwell,
        output wr_ready, code_out, code_valid, idx, busy, wrap
    );

endinterface

// File: rtl/display_sequencer_dwell_timer.sv
// Down-counter that times one digit: load with dwell, done when it reaches zero.
module dwell_timer #(
    parameter int DWELL_W = 8
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_load,
    input  logic [DWELL_W-1:0] i_load_val,
    output logic               o_done
);

    logic [DWELL_W-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - DWELL_W'(1);
        end
    end

    assign o_done = (r_cnt == '0);

endmodule

// File: rtl/display_sequencer.sv
// Nibble buffer plus round-robin scheduler feeding a 7-segment decoder.
// Optional one-cycle blanking between digits: define SEQ_BLANK_EN.
module display_sequencer
    import display_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int DWELL_W = 8
) (
    input  logic                i_clk,
    input  logic                i_rst,
    display_sequencer_if.slave  bus
);

    localparam int IW = $clog2(DEPTH);
    localparam int CW = IW + 1;

    seq_state_t          r_state;
    logic [CW-1:0]       r_count;
    logic [NIBBLE_W-1:0] r_buf [DEPTH];
    logic [IW-1:0]       r_idx;
    logic [NIBBLE_W-1:0] r_code_out;
    logic                r_code_valid;
    logic                r_busy;
    logic                r_wrap;

    logic                w_wr_ready;
    logic                w_wr_fire;
    logic                w_start_ok;
    logic                w_last;
    logic [IW-1:0]       w_idx_nxt;
    logic                w_done;
    logic                w_load;

    assign w_wr_ready = !i_rst && !bus.clear && (r_state == IDLE) &&
                        (r_count < CW'(DEPTH));
    assign w_wr_fire  = bus.wr_valid && w_wr_ready;
    // A start alongside clear would leave SHOW with an empty buffer, so clear blocks it.
    assign w_start_ok = (r_state == IDLE) && bus.start && !bus.stop &&
                        !bus.clear && (r_count != '0);
    assign w_last     = ({1'b0, r_idx} == (r_count - CW'(1)));
    assign w_idx_nxt  = w_last ? '0 : (r_idx + IW'(1));

`ifdef SEQ_BLANK_EN
    assign w_load = w_start_ok || ((r_state == BLANK) && !bus.stop);
`else
    assign w_load = w_start_ok || ((r_state == SHOW) && w_done && !bus.stop);
`endif

    dwell_timer #(.DWELL_W(DWELL_W)) u_timer (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_load     (w_load),
        .i_load_val (bus.dwell),
        .o_done     (w_done)
    );

    always_ff @(posedge i_clk) begin
        if (w_wr_fire) r_buf[r_count[IW-1:0]] <= bus.wr_data;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= IDLE;
            r_count      <= '0;
            r_idx        <= '0;
            r_code_out   <= '0;
            r_code_valid <= 1'b0;
            r_busy       <= 1'b0;
            r_wrap       <= 1'b0;
        end else begin
            r_wrap <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.clear)     r_count <= '0;
                    else if (w_wr_fire) r_count <= r_count + CW'(1);
                    if (w_start_ok) begin
                        r_state      <= SHOW;
                        r_idx        <= '0;
                        r_code_out   <= r_buf[0];
                        r_code_valid <= 1'b1;
                        r_busy       <= 1'b1;
                    end
                end
                SHOW: begin
                    if (bus.stop) begin
                        r_state      <= IDLE;
                        r_idx        <= '0;
                        r_code_valid <= 1'b0;
                        r_busy       <= 1'b0;
                    end else if (w_done) begin
`ifdef SEQ_BLANK_EN
                        r_state      <= BLANK;
                        r_code_valid <= 1'b0;
`else
                        r_idx        <= w_idx_nxt;
                        r_code_out   <= r_buf[w_idx_nxt];
                        r_wrap       <= w_last;
`endif
                    end
                end
`ifdef SEQ_BLANK_EN
                BLANK: begin
                    if (bus.stop) begin
                        r_state      <= IDLE;
                        r_idx        <= '0;
                        r_busy       <= 1'b0;
                    end else begin
                        r_state      <= SHOW;
                        r_idx        <= w_idx_nxt;
                        r_code_out   <= r_buf[w_idx_nxt];
                        r_code_valid <= 1'b1;
                        r_wrap       <= w_last;
                    end
                end
`endif
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.wr_ready   = w_wr_ready;
    assign bus.code_out   = r_code_out;
    assign bus.code_valid = r_code_valid;
    assign bus.idx        = r_idx;
    assign bus.busy       = r_busy;
    assign bus.wrap       = r_wrap;

endmodule

// File: doc/display_sequencer.md
# display_sequencer

Time-multiplexing scheduler that feeds 4-bit codes to the team's 4-bit to 7-segment decoder. It buffers up to DEPTH nibbles loaded through a valid/ready handshake. On start it presents each nibble in turn for a programmable dwell time, wrapping until stopped. It sits between the control logic or CPU-side registers and the segment decoder; the decoder itself stays outside this block.

## Interface
- DEPTH, 4: number of nibble slots (power of two, ≥2)
- DWELL_W, 8: width of dwell count
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- wr_valid  in  1  nibble write request
- wr_data  in  4  nibble to append
- wr_ready  out  1  buffer accepts a write this cycle
- clear  in  1  empty the buffer (IDLE only)
- start  in  1  begin sequencing
- stop  in  1  end sequencing
- dwell  in  DWELL_W  display time per digit minus one
- code_out  out  4  nibble to the decoder
- code_valid  out  1  code_out is to be displayed; decoder output is blanked when low
- idx  out  $clog2(DEPTH)  slot currently shown
- busy  out  1  high in SHOW/BLANK
- wrap  out  1  one-cycle pulse when idx returns to 0

## Operation
- States: IDLE, SHOW, BLANK (BLANK exists only with SEQ_BLANK_EN).
- Reset values:
  - state=IDLE, count=0, idx=0, code_out=0, code_valid=0, busy=0, wrap=0.
  - wr_ready=0 while rst is high.
- IDLE:
  - wr_ready = !rst && !clear && count<DEPTH.
  - A write is accepted on wr_valid && wr_ready: buf[count]<=wr_data, count++.
  - clear sets count=0. Clear wins over a simultaneous write.
  - start with count>0 and stop=0 → SHOW, idx=0, dwell latched.
  - start with count==0 is ignored.
  - start and stop in the same cycle: stop wins, stay in IDLE.
- SHOW:
  - code_valid=1, code_out=buf[idx], busy=1, wr_ready=0.
  - Writes and clear are ignored.
  - Dwell counter loads the latched dwell and decrements each cycle. At 0, the digit ends.
  - idx advances to idx+1, or to 0 when idx==count-1. wrap pulses for the first cycle of slot 0 after a wrap.
  - dwell is re-latched at every digit entry, so mid-digit changes apply to the next digit.
  - count==1: slot 0 repeats, and wrap pulses every dwell+1 cycles.
- stop in SHOW/BLANK → IDLE next cycle.
  - code_valid=0, idx=0, buffer contents and count are kept.
  - stop coinciding with digit end: stop wins, no advance, no wrap pulse.
- rst mid-sequence: all outputs return to reset values next cycle, and count is 0.

## Timing
- start sampled at edge t → code_valid=1 and code_out=buf[0] from t+1.
- Each digit is shown for exactly dwell+1 cycles. dwell=0 gives 1 cycle per digit.
- Without SEQ_BLANK_EN, digits are back-to-back: period per digit is dwell+1 and the full cycle is count·(dwell+1).
- stop at edge t → code_valid=0 and busy=0 from t+1.
- Write accepted at edge t → count is visible (affects wr_ready) at t+1. The maximum write rate is 1 per cycle.

## Configuration
- SEQ_BLANK_EN defined:
  - After each digit's dwell, the block spends exactly one cycle in BLANK with code_valid=0, code_out held, busy=1. This suppresses ghosting.
  - Period per digit becomes dwell+2.
  - wrap pulses on the first SHOW cycle of slot 0.
  - stop in BLANK → IDLE.
- Undefined: no BLANK state, behaviour as above.

## Structure
- Shared package display_pkg:
  - state enum seq_state_t {IDLE, SHOW, BLANK}
  - localparam NIBBLE_W=4
  - default dwell constant DWELL_DEFAULT=8'd49
- Sub-module dwell_timer:
  - DWELL_W-bit down-counter with load and a done flag.
  - Instantiated once.
- The buffer is a flat register array inside display_sequencer.

## Test plan
- Reset then load 4'h3,4'hA,4'h5,4'hF, start with dwell=2 → code_out 3,3,3,A,A,A,5,5,5,F,F,F,3…; wrap high on the first 3 of the second pass; wr_ready=0 throughout.
- Write 5 nibbles with DEPTH=4 → wr_ready drops after the 4th accept, and the 5th is not stored.
- Load 2 nibbles, start, assert stop on the last cycle of digit 1 → no wrap; IDLE next cycle; code_valid=0; count remains 2.
- start and stop together in IDLE, and start with empty buffer → busy stays 0.
- clear and wr_valid together in IDLE with count=3 → count=0, nothing written.
- SEQ_BLANK_EN, 2 nibbles, dwell=0 → code_valid pattern 1,0,1,0…; code_out alternates every 2 cycles.
